// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared definitions for the instruction fetch front end.
//   - fetch_state_t    : fetch FSM state encoding (IDLE, FETCH, HOLD)
//   - NOP              : canonical RISC-V no-op (addi x0, x0, 0)
//   - DEFAULT_RESET_PC : default first fetch address after reset
//   - align_word()     : clears the two low address bits of a byte address
// -----------------------------------------------------------------------------
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage: holds the PC, requests words from instruction
//   memory, and presents one registered instruction per cycle to decode. A
//   one-entry skid buffer catches the word that arrives in the same cycle the
//   downstream stage stalls, so no fetched word is ever lost or duplicated.
//   A taken branch (select) overrides everything and redirects the PC.
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   select        in   branch taken, redirect to branch_target
//   branch_target in   [31:0] redirect address (low two bits are dropped)
//   stall         in   downstream cannot accept an instruction this cycle
//   imem_req      out  instruction memory request (high only in FETCH)
//   imem_addr     out  [31:0] fetch address, always the PC register
//   imem_ack      in   imem_rdata valid for imem_addr this cycle
//   imem_rdata    in   [31:0] fetched instruction word
//   instr         out  [31:0] registered instruction for decode
//   pc_out        out  [31:0] registered PC of instr
//   instr_valid   out  instr/pc_out carry a real instruction
//   flush         out  one-cycle pulse the cycle after a redirect
//   misalign_err  out  one-cycle pulse alongside flush for a misaligned target
// -----------------------------------------------------------------------------
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        select,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic        flush,
  output logic        misalign_err
);

  fetch_state_t state_q, state_d;

  logic [31:0] pc_q,          pc_d;
  logic [31:0] instr_q,       instr_d;
  logic [31:0] pc_out_q,      pc_out_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] buf_instr_q,   buf_instr_d;
  logic [31:0] buf_pc_q,      buf_pc_d;
  logic        flush_q,       flush_d;
  logic        misalign_q,    misalign_d;

  // Sequential PC; wraps modulo 2^32 with no overflow indication.
  logic [31:0] pc_plus4;
  assign pc_plus4 = pc_q + 32'd4;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    pc_out_d      = pc_out_q;
    instr_valid_d = instr_valid_q;
    buf_instr_d   = buf_instr_q;
    buf_pc_d      = buf_pc_q;
    // Both pulses are only ever raised by a redirect in the previous cycle.
    flush_d       = 1'b0;
    misalign_d    = 1'b0;

    if (select) begin
      // Redirect wins over stall, ack and state. Any word acked this cycle
      // belongs to the wrong path and is dropped along with the skid entry.
      state_d       = FETCH;
      pc_d          = align_word(branch_target);
      instr_d       = NOP;
      instr_valid_d = 1'b0;
      buf_instr_d   = NOP;
      buf_pc_d      = RESET_PC;
      flush_d       = 1'b1;
      misalign_d    = (branch_target[1:0] != 2'b00);
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = FETCH;
        end

        FETCH: begin
          if (imem_ack) begin
            pc_d = pc_plus4;
            if (stall) begin
              // Decode is blocked: park the word and stop requesting until
              // it has been handed over.
              buf_instr_d = imem_rdata;
              buf_pc_d    = pc_q;
              state_d     = HOLD;
            end else begin
              instr_d       = imem_rdata;
              pc_out_d      = pc_q;
              instr_valid_d = 1'b1;
            end
          end else if (!stall) begin
            // Memory has nothing yet and decode consumed the last word.
            instr_valid_d = 1'b0;
          end
        end

        HOLD: begin
          if (!stall) begin
            instr_d       = buf_instr_q;
            pc_out_d      = buf_pc_q;
            instr_valid_d = 1'b1;
            state_d       = FETCH;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= NOP;
      pc_out_q      <= RESET_PC;
      instr_valid_q <= 1'b0;
      buf_instr_q   <= NOP;
      buf_pc_q      <= RESET_PC;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      pc_out_q      <= pc_out_d;
      instr_valid_q <= instr_valid_d;
      buf_instr_q   <= buf_instr_d;
      buf_pc_q      <= buf_pc_d;
      flush_q       <= flush_d;
      misalign_q    <= misalign_d;
    end
  end

  // Request only while actively fetching; IDLE and HOLD never request.
  assign imem_req     = (state_q == FETCH);
  assign imem_addr    = pc_q;
  assign instr        = instr_q;
  assign pc_out       = pc_out_q;
  assign instr_valid  = instr_valid_q;
  assign flush        = flush_q;
  assign misalign_err = misalign_q;

endmodule
